// File: rtl/key_debounce.sv
// key_debounce: debounces one synchronized key level and derives press,
// release, long-press and auto-repeat strobes. Timing is in clk cycles.
// The release and repeat strobes are named release_pulse / repeat_pulse
// because "release" and "repeat" are SystemVerilog keywords.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 20000,
    parameter int unsigned LONG_CYC     = 1000000,
    parameter int unsigned REPEAT_CYC   = 200000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       rising,
    input  logic       falling,
    output logic       out,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic [7:0] bounce_cnt
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DB  = 3'd1,
        HELD      = 3'd2,
        LONG_HELD = 3'd3,
        REL_DB    = 3'd4
    } state_t;

    state_t              state;
    logic [DB_W-1:0]     db_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                was_long;   // held state to return to after a release glitch
    logic                act;
    logic                any_edge;

    assign act      = in ^ ACTIVE_LOW;
    assign any_edge = rising | falling;

    // Debounce FSM with hold timers, registered strobes and bounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            was_long      <= 1'b0;
            out           <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            bounce_cnt    <= '0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            // Only edges arriving inside a debounce window count as bounces
            if ((state == PRESS_DB || state == REL_DB) && any_edge && bounce_cnt != 8'hFF)
                bounce_cnt <= bounce_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (act) begin
                        state  <= PRESS_DB;
                        db_cnt <= DB_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (!act) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= HELD;
                        db_cnt   <= '0;
                        out      <= 1'b1;
                        press    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!act) begin
                        state    <= REL_DB;
                        db_cnt   <= DB_W'(1);
                        was_long <= 1'b0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state      <= LONG_HELD;
                        long_press <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (!act) begin
                        state    <= REL_DB;
                        db_cnt   <= DB_W'(1);
                        was_long <= 1'b1;
                    end else if (REPEAT_CYC > 0) begin
                        if (hold_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                REL_DB: begin
                    if (act) begin
                        state  <= was_long ? LONG_HELD : HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        db_cnt        <= '0;
                        out           <= 1'b0;
                        release_pulse <= 1'b1;
                        hold_cnt      <= '0;
                        was_long      <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Key/button conditioning stage that sits directly downstream of the synchronizing edge-detect stage.
- Consumes that stage's synchronized level and its single-cycle rising/falling strobes.
- Produces a debounced level plus single-cycle press, release, long-press and auto-repeat strobes for UI/control logic.
- One instance per physical key; all timing is in clk cycles.

Parameters:
- DEBOUNCE_CYC, 20000: consecutive stable samples needed to accept a level change. Must be ≥1.
- LONG_CYC, 1000000: cycles from the press strobe to the long_press strobe. Must be ≥1.
- REPEAT_CYC, 200000: period of repeat strobes after long_press. 0 disables repeat.
- ACTIVE_LOW, 1: 1 means key pressed when in==0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in  in  1  synchronized key level from edge-detect stage
- rising  in  1  1-cycle strobe, in went 0→1
- falling  in  1  1-cycle strobe, in went 1→0
- out  out  1  debounced pressed level, 1 = pressed
- press  out  1  1-cycle strobe on accepted press
- release  out  1  1-cycle strobe on accepted release
- long_press  out  1  1-cycle strobe when held LONG_CYC cycles after press
- repeat  out  1  1-cycle strobe every REPEAT_CYC cycles while long-held
- bounce_cnt  out  8  saturating count of edge strobes seen during debounce windows

Behaviour:
- Definitions:
  - act = in XOR ACTIVE_LOW.
  - edge = rising OR falling.
- Outputs and counters:
  - All outputs are registered.
  - Two counters: db_cnt (debounce) and hold_cnt (long/repeat), each sized by $clog2 of its largest limit.
- Reset (async, any time, including mid-debounce or mid-hold):
  - state=IDLE, out=0, all strobes=0, db_cnt=0, hold_cnt=0, bounce_cnt=0.
  - No release strobe is emitted for a key held across reset.
- IDLE (out=0):
  - act=1 sampled → PRESS_DB, db_cnt=1.
- PRESS_DB (out=0):
  - act=0 → IDLE, db_cnt=0 (bounce rejected).
  - act=1 and db_cnt==DEBOUNCE_CYC → HELD; out=1, press=1 for one cycle; hold_cnt=0.
  - Otherwise db_cnt++.
  - Net effect: with act=1 at sampling edges 0..DEBOUNCE_CYC, press is high in the cycle after edge DEBOUNCE_CYC.
  - If DEBOUNCE_CYC=1, press follows the second active sample.
- HELD (out=1):
  - hold_cnt++ each cycle.
  - hold_cnt reaching LONG_CYC-1 → long_press=1 next cycle, LONG_HELD, hold_cnt=0.
  - act=0 → REL_DB, db_cnt=1, hold_cnt frozen.
- LONG_HELD (out=1):
  - If REPEAT_CYC>0: hold_cnt++; on reaching REPEAT_CYC-1, repeat=1 next cycle and hold_cnt=0.
  - act=0 → REL_DB, db_cnt=1, hold_cnt frozen.
- REL_DB (out stays 1):
  - act=1 → return to the held state that was left (HELD or LONG_HELD, tracked by a 1-bit flag); db_cnt=0; hold_cnt resumes from its frozen value.
  - act=0 and db_cnt==DEBOUNCE_CYC → IDLE; out=0, release=1 for one cycle; hold_cnt=0.
  - Otherwise db_cnt++.
- Strobe timing rules:
  - press/release and out change in the same cycle.
  - long_press and repeat are never asserted in the same cycle; the first repeat comes REPEAT_CYC cycles after long_press.
  - No strobes are emitted in IDLE, PRESS_DB or REL_DB, other than release on exit from REL_DB.
- bounce_cnt:
  - Increments by 1 on each edge while state is PRESS_DB or REL_DB.
  - Saturates at 255 and is cleared only by rst.
  - Edges in IDLE/HELD/LONG_HELD do not count; the strobe that triggers IDLE→PRESS_DB arrives in IDLE and is not counted.
- Input inconsistency:
  - in is authoritative for state transitions; rising/falling are used only for bounce_cnt.
  - If rising and falling are asserted together (illegal upstream), bounce_cnt increments by 1.

Test Plan:
1. DEBOUNCE_CYC=4, ACTIVE_LOW=1: drive in 1→0 and hold → press=1 exactly 5 cycles after the first low sample, out=1 from that cycle, bounce_cnt=0.
2. DEBOUNCE_CYC=4: in low 2 cycles, high 1, low 1, high, with correct edge strobes → no press, out=0, state IDLE, bounce_cnt=2.
3. DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3: hold pressed 30 cycles → long_press 10 cycles after press, then repeat at +3, +6, …, never coincident with long_press.
4. Same parameters, after long_press: release glitch of 2 cycles, then re-press → no release strobe, repeat spacing continues from the frozen hold_cnt.
5. Release cleanly for 5 samples → release=1 once, out=0, hold_cnt=0; a subsequent press repeats scenario 1 timing.
6. Assert rst mid-HELD, asynchronously between clock edges → all outputs 0 immediately, no release strobe; REPEAT_CYC=0 variant → no repeat ever after long_press.
